// File: rtl/lfsr_weight_scheduler.sv
// Round-robin scheduler sharing one 16-bit Fibonacci LFSR weight source between NREQ requesters.
// Optional build macro LFSR_ZERO_GUARD_EN: a zero seed_load loads SEED so the LFSR never locks at 0.
module lfsr_weight_scheduler #(
    parameter int          NREQ  = 4,
    parameter int          BURST = 8,
    parameter logic [15:0] SEED  = 16'h632C,
    localparam int         IW    = $clog2(BURST),
    localparam int         PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     w_data,
    output logic            w_valid,
    input  logic            w_ready,
    output logic [IW-1:0]   w_idx,
    output logic            w_last,
    input  logic            seed_load,
    input  logic [15:0]     seed_in,
    output logic            busy
);

    typedef enum logic {IDLE, STREAM} state_t;

    typedef struct packed {
        logic          found;
        logic [PW-1:0] idx;
    } pick_t;

    // Lowest offset from the pointer wins; scanning downward lets it overwrite last.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
        pick_t p;
        int    j;
        p = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (r[j]) begin
                p.found = 1'b1;
                p.idx   = PW'(j);
            end
        end
        return p;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] d);
        return {d[14:0], d[15] ^ d[14] ^ d[12] ^ d[3]};
    endfunction

    state_t          state, state_n;
    logic [15:0]     lfsr, lfsr_n, seed_eff;
    logic [NREQ-1:0] gnt_n, pick_oh;
    logic [IW-1:0]   idx_n;
    logic [PW-1:0]   rr_ptr, rr_n, cur, cur_n;
    pick_t           pick;
    logic            accept;

    assign pick = rr_pick(req, rr_ptr);

    for (genvar g = 0; g < NREQ; g++) begin : g_oh
        assign pick_oh[g] = pick.found && (pick.idx == PW'(g));
    end

`ifdef LFSR_ZERO_GUARD_EN
    assign seed_eff = (seed_in == 16'h0000) ? SEED : seed_in;
`else
    assign seed_eff = seed_in;
`endif

    assign accept  = (state == STREAM) && w_ready;
    assign w_valid = (state == STREAM);
    assign busy    = (state == STREAM);
    assign w_data  = lfsr;
    assign w_last  = w_valid && (w_idx == IW'(BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lfsr   <= SEED;
            gnt    <= '0;
            w_idx  <= '0;
            rr_ptr <= '0;
            cur    <= '0;
        end else begin
            state  <= state_n;
            lfsr   <= lfsr_n;
            gnt    <= gnt_n;
            w_idx  <= idx_n;
            rr_ptr <= rr_n;
            cur    <= cur_n;
        end
    end

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        gnt_n   = gnt;
        idx_n   = w_idx;
        rr_n    = rr_ptr;
        cur_n   = cur;
        case (state)
            IDLE: begin
                // Seed reload takes the cycle; any pending request waits one clock.
                if (seed_load) begin
                    lfsr_n = seed_eff;
                end else if (pick.found) begin
                    state_n = STREAM;
                    gnt_n   = pick_oh;
                    idx_n   = '0;
                    cur_n   = pick.idx;
                end
            end
            STREAM: begin
                if (accept) begin
                    lfsr_n = lfsr_step(lfsr);
                    if (w_idx == IW'(BURST - 1)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                        rr_n    = (cur == PW'(NREQ - 1)) ? '0 : cur + PW'(1);
                    end else begin
                        idx_n = w_idx + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_weight_scheduler.sv
// Scoreboard bench for lfsr_weight_scheduler: model queues expected words, monitor pops on accept.
module tb_lfsr_weight_scheduler;
    localparam int          NREQ  = 4;
    localparam int          BURST = 8;
    localparam logic [15:0] SEED  = 16'h632C;
    localparam int          IW    = $clog2(BURST);

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [15:0]     data;
        logic [IW-1:0]   idx;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [15:0]     w_data;
    logic            w_valid;
    logic            w_ready = 1'b0;
    logic [IW-1:0]   w_idx;
    logic            w_last;
    logic            seed_load = 1'b0;
    logic [15:0]     seed_in = '0;
    logic            busy;

    lfsr_weight_scheduler #(.NREQ(NREQ), .BURST(BURST), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_idx(w_idx), .w_last(w_last), .seed_load(seed_load),
        .seed_in(seed_in), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   bursts_done = 0;
    int   target = 0;
    exp_t q[$];

    // Reference model state: current LFSR word and round-robin pointer.
    logic [15:0] m_lfsr = SEED;
    int          m_rr = 0;

    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] d);
        logic fb;
        fb = d[15] ^ d[14] ^ d[12] ^ d[3];
        return (16'((d << 1) & 16'hFFFF)) | {15'b0, fb};
    endfunction

    function automatic logic [15:0] model_seed(input logic [15:0] s);
`ifdef LFSR_ZERO_GUARD_EN
        return (s == 16'h0000) ? SEED : s;
`else
        return s;
`endif
    endfunction

    task automatic push_burst(input logic [NREQ-1:0] r);
        int   w;
        exp_t e;
        w = -1;
        for (int i = 0; i < NREQ; i++)
            if (w < 0 && r[(m_rr + i) % NREQ]) w = (m_rr + i) % NREQ;
        for (int k = 0; k < BURST; k++) begin
            e.gnt  = NREQ'(1) << w;
            e.data = m_lfsr;
            e.idx  = IW'(k);
            e.last = (k == BURST - 1);
            q.push_back(e);
            m_lfsr = model_step(m_lfsr);
        end
        m_rr = (w + 1) % NREQ;
    endtask

    // Random or forced backpressure, applied after the stimulus slot each cycle.
    always begin
        @(posedge clk);
        #2;
        w_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor: compare each accepted word, hold stability under stall, and the idle gap.
    logic        stall_prev = 1'b0;
    logic        last_prev = 1'b0;
    logic [31:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (last_prev) check("idle_gap", 32'(w_valid), 32'(0));
            if (stall_prev && w_valid) check("stall_hold", 32'({w_data, w_idx, gnt}), held);
            last_prev = 1'b0;
            if (w_valid && w_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 32'(w_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("word", 32'({gnt, w_data, w_idx, w_last}), 32'({e.gnt, e.data, e.idx, e.last}));
                    check("busy", 32'(busy), 32'(1));
                    if (e.last) begin
                        bursts_done++;
                        last_prev = 1'b1;
                    end
                end
            end
            stall_prev = w_valid && !w_ready;
            held = 32'({w_data, w_idx, gnt});
        end
    end

    task automatic start(input logic [NREQ-1:0] r, input int n);
        req = r;
        target = bursts_done + n;
        for (int k = 0; k < n; k++) push_burst(r);
        @(posedge clk); #1;
        check("grant_latency", 32'({w_valid, busy}), 32'(2'b11));
    endtask

    task automatic finish_bursts();
        int c;
        c = 0;
        while (bursts_done < target && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        if (bursts_done < target) check("burst_timeout", 32'(bursts_done), 32'(target));
        req = '0;
    endtask

    task automatic wait_idx(input int v);
        int c;
        c = 0;
        while (!(w_valid && w_idx == IW'(v)) && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 1000) check("idx_timeout", 32'(w_idx), 32'(v));
    endtask

    task automatic seed_then_burst(input logic [15:0] s, input logic [NREQ-1:0] r);
        seed_load = 1'b1;
        seed_in   = s;
        req       = r;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr    = model_seed(s);
        check("seed_no_grant", 32'({w_valid, gnt}), 32'(0));
        check("seed_loaded", 32'(w_data), 32'(m_lfsr));
        start(r, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({gnt, w_valid, w_idx, w_last, busy}), 32'(0));
        check("reset_data", 32'(w_data), 32'(SEED));
        rst = 1'b0;
        @(posedge clk); #1;

        // Single requester, no backpressure.
        start(4'b0001, 1);
        finish_bursts();

        // All requesting: rotating grants, random backpressure.
        rdy_rand = 1'b1;
        start(4'b1111, 5);
        finish_bursts();

        // Five-cycle stall mid-burst.
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        start(4'b0001, 1);
        wait_idx(3);
        rdy_force = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("stall_idx", 32'(w_idx), 32'(3));
        rdy_force = 1'b1;
        finish_bursts();

        // Seed reload in IDLE, then seed_load during STREAM ignored.
        rdy_rand = 1'b1;
        seed_then_burst(16'h1234, 4'b0001);
        finish_bursts();
        start(4'b0010, 1);
        wait_idx(2);
        seed_load = 1'b1;
        seed_in   = 16'(($urandom() & 32'hFFFF) | 32'h1);
        repeat (2) begin @(posedge clk); #1; end
        seed_load = 1'b0;
        finish_bursts();

        // Reset mid-burst discards it and restarts from SEED with pointer 0.
        start(4'b1111, 1);
        wait_idx(3);
        rst = 1'b1;
        #1;
        check("midreset_outputs", 32'({gnt, w_valid, w_idx, w_last, busy}), 32'(0));
        check("midreset_data", 32'(w_data), 32'(SEED));
        q.delete();
        m_lfsr = SEED;
        m_rr   = 0;
        req    = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start(4'b1111, 1);
        check("rr_after_reset", 32'(gnt), 32'(4'b0001));
        finish_bursts();

        // Zero seed: guarded build reloads SEED, otherwise locks at zero.
        seed_then_burst(16'h0000, 4'b0100);
        finish_bursts();

        // Random requests.
        for (int it = 0; it < 8; it++) begin
            logic [NREQ-1:0] r;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            if ($urandom_range(0, 1) == 1) begin
                seed_then_burst(16'($urandom_range(0, 16'hFFFF)), r);
            end else begin
                start(r, $urandom_range(1, 2));
            end
            finish_bursts();
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drain", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
